branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand and address width; legal values 32 or 64.
REQ-002 SHALL have parameter BHT_DEPTH, default 16: number of 2-bit predictor counters; power of 2, minimum 2; IDXW = log2(BHT_DEPTH).
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: branch request valid.
REQ-006 SHALL have port in_ready, output, 1: unit can accept a request.
REQ-007 SHALL have port op, input, 3: funct3 (000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu).
REQ-008 SHALL have ports data1 and data2, input, XLEN each: rs1 and rs2 operands.
REQ-009 SHALL have ports pc and imm, input, XLEN each: branch PC and sign-extended offset.
REQ-010 SHALL have ports lk_pc, input, XLEN, and lk_taken, output, 1: fetch-side prediction lookup.
REQ-011 SHALL have port out_valid, output, 1: result valid.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-013 SHALL have ports taken, mispredict and illegal, output, 1 each: resolved direction, prediction-miss flag and unsupported-op flag.
REQ-014 SHALL have port redirect_pc, output, XLEN: correct next PC.
REQ-015 SHALL have ports br_cnt and mp_cnt, output, 32 each: count of resolved legal branches and count of mispredicts.

Function
REQ-016 SHALL accept a request on any rising edge where in_valid and in_ready are both 1.
REQ-017 SHALL drive in_ready = !out_valid || out_ready, combinationally; no other dependency.
REQ-018 SHALL present the result registered, with out_valid rising on the edge after acceptance: latency 1, throughput 1 per cycle.
REQ-019 SHALL hold out_valid and every result output stable while out_valid=1 and out_ready=0.
REQ-020 SHALL clear out_valid on an edge where out_valid=1, out_ready=1 and no new request is accepted.
REQ-021 SHALL, on an edge where the output drains and a new request is accepted together, load the new result with out_valid staying 1.
REQ-022 SHALL compute the direction per op: signed compare for blt/bge; unsigned compare for bltu/bgeu; full XLEN equality for beq/bne.
REQ-023 SHALL treat op 010 or 011 as illegal: taken=0, mispredict=0, illegal=1, redirect_pc = pc+4, no predictor update, no counter increment.
REQ-024 SHALL compute target = pc + imm and fall-through = pc + 4, both modulo 2^XLEN (wrap-around, no overflow flag).
REQ-025 SHALL set redirect_pc = target when taken, else fall-through.
REQ-026 SHALL index the predictor by pc[IDXW+1:2]; lk_taken uses lk_pc[IDXW+1:2]; all other PC bits are ignored.
REQ-027 SHALL define predicted direction = bit 1 of the indexed counter, sampled at acceptance; mispredict = predicted XOR taken.
REQ-028 SHALL update the indexed counter on the acceptance edge: +1 if taken, -1 if not taken; saturate at 11 and 00.
REQ-029 SHALL make lk_taken a combinational read of the current counter; a same-cycle update to the same index is visible only after the edge.
REQ-030 SHALL, for back-to-back requests to the same index, make the second request see the counter value written by the first.
REQ-031 SHALL increment br_cnt per accepted legal request and mp_cnt per accepted mispredict, both on the acceptance edge; both wrap from 0xFFFFFFFF to 0.

Reset
REQ-032 SHALL, while rst_n=0, force out_valid, taken, mispredict and illegal to 0; redirect_pc, br_cnt and mp_cnt to 0; every counter to 01 (weakly not-taken).
REQ-033 SHALL discard any held result when reset asserts mid-transfer; after release, in_ready=1 and no stale result is ever presented.

Verification
REQ-034 SHALL cover: beq, data1=data2=5, pc=0x100, imm=0x20, fresh reset -> taken=1, mispredict=1, redirect_pc=0x120, counter[0] becomes 10, br_cnt=1, mp_cnt=1.
REQ-035 SHALL cover: blt with data1=0xFFFFFFFF, data2=1 -> taken=1; bltu with the same operands -> taken=0, redirect_pc=pc+4.
REQ-036 SHALL cover: four taken bne at pc=0x40 -> counter saturates at 11, lk_taken=1 for lk_pc=0x40 and for lk_pc=0x80 (aliased index, BHT_DEPTH=16), mispredict only on the first request.
REQ-037 SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> result held stable, in_ready=0, one accept only; out_ready=1 -> queued request accepted on the drain edge.
REQ-038 SHALL cover: op=011 -> illegal=1, taken=0, counters and predictor unchanged; pc=0xFFFFFFF0, imm=0x20, beq taken -> redirect_pc=0x10.
REQ-039 SHALL cover: rst_n asserted while out_valid=1 and out_ready=0 -> out_valid=0 immediately, br_cnt=0, lk_taken=0 for every index.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves RISC-V conditional branches with a 2-bit BHT predictor
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready : request handshake (op, data1, data2, pc, imm)
//   lk_pc/lk_taken    : fetch-side prediction lookup (combinational)
//   out_valid/ready   : registered result handshake (taken, mispredict, illegal, redirect_pc)
//   br_cnt/mp_cnt     : resolved legal branch and mispredict counters
module branch_resolve_unit #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] lk_pc,
    output logic            lk_taken,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            taken,
    output logic            mispredict,
    output logic            illegal,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     br_cnt,
    output logic [31:0]     mp_cnt
);
    localparam int IDXW = $clog2(BHT_DEPTH);

    logic [1:0]      bht_q [BHT_DEPTH];
    logic [1:0]      bht_d [BHT_DEPTH];
    logic            out_valid_q, out_valid_d;
    logic            taken_q, taken_d;
    logic            mispredict_q, mispredict_d;
    logic            illegal_q, illegal_d;
    logic [XLEN-1:0] redirect_q, redirect_d;
    logic [31:0]     br_cnt_q, br_cnt_d;
    logic [31:0]     mp_cnt_q, mp_cnt_d;

    logic            accept, is_illegal, cond, br_taken, pred;
    logic [IDXW-1:0] idx;
    logic [1:0]      ctr;
    logic            unused_lk;

    assign in_ready  = !out_valid_q || out_ready;
    assign idx       = pc[IDXW+1:2];
    assign lk_taken  = bht_q[lk_pc[IDXW+1:2]][1];
    assign unused_lk = ^{lk_pc[XLEN-1:IDXW+2], lk_pc[1:0]};

    always_comb begin
        accept     = in_valid && in_ready;
        is_illegal = (op[2:1] == 2'b01);
        // op[2] selects compare vs equality, op[1] unsigned, op[0] inverts the sense
        cond       = op[2] ? (op[1] ? (data1 < data2) : ($signed(data1) < $signed(data2)))
                           : (data1 == data2);
        br_taken   = !is_illegal && (cond ^ op[0]);
        ctr        = bht_q[idx];
        pred       = ctr[1];
        bht_d        = bht_q;
        out_valid_d  = out_valid_q;
        taken_d      = taken_q;
        mispredict_d = mispredict_q;
        illegal_d    = illegal_q;
        redirect_d   = redirect_q;
        br_cnt_d     = br_cnt_q;
        mp_cnt_d     = mp_cnt_q;
        if (accept) begin
            out_valid_d  = 1'b1;
            taken_d      = br_taken;
            mispredict_d = !is_illegal && (pred ^ br_taken);
            illegal_d    = is_illegal;
            redirect_d   = br_taken ? pc + imm : pc + XLEN'(4);
            if (!is_illegal) begin
                bht_d[idx] = br_taken ? ((ctr == 2'b11) ? ctr : ctr + 2'b01)
                                      : ((ctr == 2'b00) ? ctr : ctr - 2'b01);
                br_cnt_d   = br_cnt_q + 32'd1;
                mp_cnt_d   = mp_cnt_q + {31'd0, pred ^ br_taken};
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bht_q        <= '{default: 2'b01};
            out_valid_q  <= 1'b0;
            taken_q      <= 1'b0;
            mispredict_q <= 1'b0;
            illegal_q    <= 1'b0;
            redirect_q   <= '0;
            br_cnt_q     <= '0;
            mp_cnt_q     <= '0;
        end else begin
            bht_q        <= bht_d;
            out_valid_q  <= out_valid_d;
            taken_q      <= taken_d;
            mispredict_q <= mispredict_d;
            illegal_q    <= illegal_d;
            redirect_q   <= redirect_d;
            br_cnt_q     <= br_cnt_d;
            mp_cnt_q     <= mp_cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign taken       = taken_q;
    assign mispredict  = mispredict_q;
    assign illegal     = illegal_q;
    assign redirect_pc = redirect_q;
    assign br_cnt      = br_cnt_q;
    assign mp_cnt      = mp_cnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic [31:0] data1 = '0, data2 = '0, pc = '0, imm = '0, lk_pc = '0;
    logic        lk_taken, out_valid, out_ready = 1'b1;
    logic        taken, mispredict, illegal;
    logic [31:0] redirect_pc, br_cnt, mp_cnt;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] lk_all;

    branch_resolve_unit #(.XLEN(32), .BHT_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .data1(data1), .data2(data2), .pc(pc), .imm(imm),
        .lk_pc(lk_pc), .lk_taken(lk_taken), .out_valid(out_valid), .out_ready(out_ready),
        .taken(taken), .mispredict(mispredict), .illegal(illegal),
        .redirect_pc(redirect_pc), .br_cnt(br_cnt), .mp_cnt(mp_cnt)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_req(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] p, input logic [31:0] i);
        op = o; data1 = a; data2 = b; pc = p; imm = i;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [31:0] i);
        set_req(o, a, b, p, i);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic scan_lk();
        for (int i = 0; i < 16; i++) begin
            lk_pc = 32'(i) << 2;
            #1 lk_all[i] = lk_taken;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, taken, mispredict, illegal, in_ready} !== 5'b00001) begin
            n_fail++; $display("FAIL reset_flags got %b want 00001", {out_valid, taken, mispredict, illegal, in_ready});
        end
        n_checks++;
        if ({redirect_pc, br_cnt, mp_cnt} !== 96'd0) begin
            n_fail++; $display("FAIL reset_regs got %h %h %h want 0 0 0", redirect_pc, br_cnt, mp_cnt);
        end
        scan_lk();
        n_checks++;
        if (lk_all !== 16'h0000) begin
            n_fail++; $display("FAIL reset_bht got %h want 0000", lk_all);
        end
        do_reset();
    endtask

    task automatic test_beq();
        do_reset();
        issue(3'b000, 32'd5, 32'd5, 32'h100, 32'h20);
        n_checks++;
        if ({out_valid, taken, mispredict, illegal} !== 4'b1110) begin
            n_fail++; $display("FAIL beq_flags got %b want 1110", {out_valid, taken, mispredict, illegal});
        end
        n_checks++;
        if (redirect_pc !== 32'h120) begin
            n_fail++; $display("FAIL beq_redirect got %h want 00000120", redirect_pc);
        end
        n_checks++;
        if ({br_cnt, mp_cnt} !== {32'd1, 32'd1}) begin
            n_fail++; $display("FAIL beq_cnt got %0d %0d want 1 1", br_cnt, mp_cnt);
        end
        lk_pc = 32'h100;
        #1;
        n_checks++;
        if (lk_taken !== 1'b1) begin
            n_fail++; $display("FAIL beq_lk got %b want 1", lk_taken);
        end
    endtask

    task automatic test_compare();
        issue(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10);
        n_checks++;
        if ({taken, mispredict, illegal, redirect_pc} !== {3'b100, 32'h210}) begin
            n_fail++; $display("FAIL blt got %b %h want 100 00000210", {taken, mispredict, illegal}, redirect_pc);
        end
        issue(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h204, 32'h10);
        n_checks++;
        if ({taken, mispredict, illegal, redirect_pc} !== {3'b000, 32'h208}) begin
            n_fail++; $display("FAIL bltu got %b %h want 000 00000208", {taken, mispredict, illegal}, redirect_pc);
        end
        issue(3'b000, 32'h8000_0005, 32'd5, 32'h8, 32'h40);
        n_checks++;
        if ({taken, mispredict, redirect_pc} !== {2'b00, 32'hC}) begin
            n_fail++; $display("FAIL beq_neq got %b %h want 00 0000000c", {taken, mispredict}, redirect_pc);
        end
        issue(3'b101, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h40);
        n_checks++;
        if ({taken, redirect_pc} !== {1'b0, 32'h14}) begin
            n_fail++; $display("FAIL bge got %b %h want 0 00000014", taken, redirect_pc);
        end
        issue(3'b111, 32'hFFFF_FFFF, 32'd1, 32'hC, 32'h40);
        n_checks++;
        if ({taken, mispredict, redirect_pc} !== {2'b11, 32'h4C}) begin
            n_fail++; $display("FAIL bgeu got %b %h want 11 0000004c", {taken, mispredict}, redirect_pc);
        end
        n_checks++;
        if ({br_cnt, mp_cnt} !== {32'd6, 32'd2}) begin
            n_fail++; $display("FAIL cmp_cnt got %0d %0d want 6 2", br_cnt, mp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_req(3'b001, 32'd1, 32'd2, 32'h40, 32'h10);
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if ({out_valid, taken, mispredict, redirect_pc} !== {2'b11, k == 0, 32'h50}) begin
                n_fail++; $display("FAIL b2b_%0d got %b %h want %b 00000050", k, {out_valid, taken, mispredict}, redirect_pc, {2'b11, k == 0});
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if ({br_cnt, mp_cnt} !== {32'd4, 32'd1}) begin
            n_fail++; $display("FAIL b2b_cnt got %0d %0d want 4 1", br_cnt, mp_cnt);
        end
        scan_lk();
        lk_pc = 32'h80;
        #1;
        n_checks++;
        if ({lk_all[0], lk_all[1], lk_taken} !== 3'b101) begin
            n_fail++; $display("FAIL b2b_lk got %b want 101", {lk_all[0], lk_all[1], lk_taken});
        end
        issue(3'b000, 32'd1, 32'd2, 32'h8, 32'h4);
        issue(3'b000, 32'd1, 32'd2, 32'h8, 32'h4);
        issue(3'b000, 32'd1, 32'd1, 32'h8, 32'h4);
        n_checks++;
        if ({taken, mispredict, redirect_pc} !== {2'b11, 32'hC}) begin
            n_fail++; $display("FAIL sat_low got %b %h want 11 0000000c", {taken, mispredict}, redirect_pc);
        end
        n_checks++;
        if ({br_cnt, mp_cnt} !== {32'd7, 32'd2}) begin
            n_fail++; $display("FAIL sat_cnt got %0d %0d want 7 2", br_cnt, mp_cnt);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        set_req(3'b000, 32'd3, 32'd3, 32'h300, 32'h8);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        set_req(3'b001, 32'd3, 32'd3, 32'h310, 32'h8);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({out_valid, taken, mispredict, illegal, in_ready, redirect_pc, br_cnt} !== {5'b11100, 32'h308, 32'd1}) begin
                n_fail++; $display("FAIL hold_%0d got %b %h %0d want 11100 00000308 1", k, {out_valid, taken, mispredict, illegal, in_ready}, redirect_pc, br_cnt);
            end
            if (k < 3) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL drain_ready got %b want 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, taken, mispredict, redirect_pc, br_cnt, mp_cnt} !== {3'b100, 32'h314, 32'd2, 32'd1}) begin
            n_fail++; $display("FAIL drain_load got %b %h %0d %0d want 100 00000314 2 1", {out_valid, taken, mispredict}, redirect_pc, br_cnt, mp_cnt);
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL drain_clear got %b want 0", out_valid);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        issue(3'b000, 32'd7, 32'd7, 32'h40, 32'h8);
        issue(3'b010, 32'd7, 32'd7, 32'h40, 32'h100);
        lk_pc = 32'h40;
        #1;
        n_checks++;
        if ({out_valid, taken, mispredict, illegal, lk_taken, redirect_pc} !== {5'b10011, 32'h44}) begin
            n_fail++; $display("FAIL illegal_010 got %b %h want 10011 00000044", {out_valid, taken, mispredict, illegal, lk_taken}, redirect_pc);
        end
        issue(3'b011, 32'd1, 32'd2, 32'h40, 32'h100);
        #1;
        n_checks++;
        if ({taken, mispredict, illegal, lk_taken, redirect_pc, br_cnt, mp_cnt} !== {4'b0011, 32'h44, 32'd1, 32'd1}) begin
            n_fail++; $display("FAIL illegal_011 got %b %h %0d %0d want 0011 00000044 1 1", {taken, mispredict, illegal, lk_taken}, redirect_pc, br_cnt, mp_cnt);
        end
        issue(3'b000, 32'd9, 32'd9, 32'hFFFF_FFF0, 32'h20);
        n_checks++;
        if ({taken, mispredict, illegal, redirect_pc, br_cnt, mp_cnt} !== {3'b110, 32'h10, 32'd2, 32'd2}) begin
            n_fail++; $display("FAIL wrap got %b %h %0d %0d want 110 00000010 2 2", {taken, mispredict, illegal}, redirect_pc, br_cnt, mp_cnt);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        issue(3'b000, 32'd1, 32'd1, 32'h0, 32'h4);
        lk_pc = 32'h0;
        #1;
        n_checks++;
        if ({out_valid, lk_taken} !== 2'b11) begin
            n_fail++; $display("FAIL mid_pre got %b want 11", {out_valid, lk_taken});
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, taken, redirect_pc, br_cnt, mp_cnt} !== {2'b00, 96'd0}) begin
            n_fail++; $display("FAIL mid_reset got %b %h %0d %0d want 00 0 0 0", {out_valid, taken}, redirect_pc, br_cnt, mp_cnt);
        end
        scan_lk();
        n_checks++;
        if (lk_all !== 16'h0000) begin
            n_fail++; $display("FAIL mid_bht got %h want 0000", lk_all);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if ({out_valid, in_ready} !== 2'b01) begin
                n_fail++; $display("FAIL mid_stale_%0d got %b want 01", k, {out_valid, in_ready});
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_beq();
        test_compare();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
